// File: rtl/mvm_pkg.sv
// Shared types and default sizing for the matrix-vector multiply sequencer.
//   mvm_state_e : controller state encoding (IDLE, LOAD_X, LOAD_A, COMPUTE, OUTPUT)
//   mvm_tag_t   : per-MAC tag carried alongside the read/multiply pipeline
//   *_DEF       : default M, N, AW and PIPE_LAT values
package mvm_pkg;

  localparam int unsigned M_DEF        = 4;
  localparam int unsigned N_DEF        = 4;
  localparam int unsigned AW_DEF       = 6;
  localparam int unsigned PIPE_LAT_DEF = 2;

  // Row index width carried in the tag; sized from the default row count.
  localparam int unsigned ROW_W = (M_DEF > 1) ? $clog2(M_DEF) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_X  = 3'd1,
    ST_LOAD_A  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_OUTPUT  = 3'd4
  } mvm_state_e;

  typedef struct packed {
    logic             valid;
    logic             first;  // column 0: accumulator restarts
    logic             last;   // column N-1: row sum complete after this MAC
    logic [ROW_W-1:0] row;
  } mvm_tag_t;

endpackage

// File: rtl/mvm_tag_pipe.sv
// Fixed-depth shift register that delays each MAC tag by the read + multiply
// latency so it arrives at the accumulator together with its product.
//   clk    : clock
//   rst_ni : asynchronous active-low clear of every stage
//   tag_i  : tag issued this cycle
//   tag_o  : tag issued DEPTH cycles ago
module mvm_tag_pipe
  import mvm_pkg::*;
#(
  parameter int unsigned DEPTH = PIPE_LAT_DEF
) (
  input  logic     clk,
  input  logic     rst_ni,
  input  mvm_tag_t tag_i,
  output mvm_tag_t tag_o
);

  mvm_tag_t pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mvm_seq_ctrl.sv
// Sequencing controller for the MxN signed matrix-vector multiply datapath.
// Loads x (N words) then A (M*N words, row-major) from a valid/ready stream,
// issues one MAC per cycle through the memory-read + multiply pipeline,
// commits each row sum to y memory, then streams y out with backpressure.
//   clk, reset         : clock, asynchronous active-low reset
//   start              : begin a job (sampled only in IDLE)
//   in_valid/in_ready  : input word handshake (x then A)
//   out_valid/out_ready: y word handshake on the datapath's data_out
//   addr_x/wr_en_x     : x memory port
//   addr_a/wr_en_a     : A memory port
//   acc_en/acc_first   : accumulator update / restart
//   addr_y/wr_en_y     : y memory port (write in COMPUTE, read in OUTPUT)
//   busy, done         : job in progress, one-cycle completion pulse
//   dbg_state          : current FSM state for observation
//
// Handshakes: a word transfers on any rising edge where valid and ready are
// both high. in_ready is a pure function of state and never depends on
// in_valid; out_valid, once high, stays high with stable data until out_ready.
module mvm_seq_ctrl
  import mvm_pkg::*;
#(
  parameter int unsigned M        = M_DEF,
  parameter int unsigned N        = N_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] addr_x,
  output logic          wr_en_x,
  output logic [AW-1:0] addr_a,
  output logic          wr_en_a,
  output logic          acc_en,
  output logic          acc_first,
  output logic [AW-1:0] addr_y,
  output logic          wr_en_y,
  output logic          busy,
  output logic          done,
  output mvm_state_e    dbg_state
);

  localparam int unsigned MN = M * N;
  localparam int unsigned PW = $clog2(MN);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = ROW_W;

  localparam logic [PW-1:0] PTR_X_LAST = PW'(N - 1);
  localparam logic [PW-1:0] PTR_A_LAST = PW'(MN - 1);
  localparam logic [PW-1:0] PTR_Y_LAST = PW'(M - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(M - 1);

  mvm_state_e    state_q;
  logic [PW-1:0] ptr_q;      // load pointer, MAC index k, or y read pointer
  logic [CW-1:0] col_q;      // c = k % N, kept as its own counter
  logic [RW-1:0] row_q;      // r = k / N
  logic          issue_q;    // MACs still being issued in COMPUTE
  logic          wr_y_q;     // registered y write strobe
  logic [RW-1:0] y_row_q;    // row being committed by wr_y_q
  logic          out_valid_q;
  logic          done_q;

  mvm_tag_t tag_d;
  mvm_tag_t tag_out;

  always_comb begin
    tag_d       = '0;
    tag_d.valid = (state_q == ST_COMPUTE) && issue_q;
    tag_d.first = (col_q == '0);
    tag_d.last  = (col_q == COL_LAST);
    tag_d.row   = row_q;
  end

  mvm_tag_pipe #(.DEPTH(PIPE_LAT)) u_tag_pipe (
    .clk    (clk),
    .rst_ni (reset),
    .tag_i  (tag_d),
    .tag_o  (tag_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      issue_q     <= 1'b0;
      wr_y_q      <= 1'b0;
      y_row_q     <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      // The accumulator holds the full row sum the cycle after a last tag exits.
      wr_y_q  <= (state_q == ST_COMPUTE) && tag_out.valid && tag_out.last;
      y_row_q <= tag_out.row;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_LOAD_X;
            ptr_q   <= '0;
          end
        end

        ST_LOAD_X: begin
          if (in_valid) begin
            if (ptr_q == PTR_X_LAST) begin
              ptr_q   <= '0;
              state_q <= ST_LOAD_A;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end

        ST_LOAD_A: begin
          if (in_valid) begin
            if (ptr_q == PTR_A_LAST) begin
              ptr_q   <= '0;
              col_q   <= '0;
              row_q   <= '0;
              issue_q <= 1'b1;
              state_q <= ST_COMPUTE;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end

        ST_COMPUTE: begin
          if (issue_q) begin
            ptr_q <= ptr_q + 1'b1;
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
            if (ptr_q == PTR_A_LAST) issue_q <= 1'b0;
          end
          // Leave only once the final row has been committed.
          if (wr_y_q && (y_row_q == ROW_LAST)) begin
            ptr_q   <= '0;
            state_q <= ST_OUTPUT;
          end
        end

        ST_OUTPUT: begin
          // addr_y changes on the handshake edge, so the registered read data
          // is stale for one cycle: drop out_valid for that bubble.
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            if (ptr_q == PTR_Y_LAST) begin
              ptr_q   <= '0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end else begin
            out_valid_q <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_LOAD_X) || (state_q == ST_LOAD_A);
    wr_en_x   = (state_q == ST_LOAD_X) && in_valid;
    wr_en_a   = (state_q == ST_LOAD_A) && in_valid;
    addr_x    = '0;
    addr_a    = '0;
    addr_y    = '0;
    case (state_q)
      ST_LOAD_X:  addr_x = AW'(ptr_q);
      ST_LOAD_A:  addr_a = AW'(ptr_q);
      ST_COMPUTE: begin
        addr_x = AW'(col_q);
        addr_a = AW'(ptr_q);
        addr_y = AW'(y_row_q);
      end
      ST_OUTPUT:  addr_y = AW'(ptr_q);
      default: ;
    endcase
    acc_en    = (state_q == ST_COMPUTE) && tag_out.valid;
    acc_first = acc_en && tag_out.first;
    wr_en_y   = wr_y_q;
    out_valid = out_valid_q;
    busy      = (state_q != ST_IDLE);
    done      = done_q;
    dbg_state = state_q;
  end

endmodule

// File: doc/mvm_seq_ctrl.md
Name: mvm_seq_ctrl

Overview:
Sequencing controller for the 4x4 signed matrix-vector multiply datapath: x memory, A memory, pipelined multiplier and accumulator, and y memory.
- Accepts a valid/ready input stream (x then A, row-major).
- Schedules one MAC per cycle through the read/multiply pipeline and commits row sums to y memory.
- Streams y out with backpressure.
- Replaces the ad-hoc counter/flag control with a single, parameterised, handshake-clean FSM.

Parameters:
M, 4, matrix rows / y length
N, 4, matrix columns / x length
AW, 6, memory address width
PIPE_LAT, 2, cycles from read address issue to product valid at accumulator input (1 memory read + 1 multiplier register)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin job; sampled only in IDLE
in_valid  in  1  data_in word valid
in_ready  out  1  controller can accept data_in word
out_valid  out  1  y memory read data valid on data_out
out_ready  in  1  consumer accepts data_out
addr_x  out  AW  x memory address
wr_en_x  out  1  x memory write enable
addr_a  out  AW  A memory address
wr_en_a  out  1  A memory write enable
acc_en  out  1  accumulator updates this cycle
acc_first  out  1  with acc_en: acc <= product (not product+acc)
addr_y  out  AW  y memory address (write in COMPUTE, read in OUTPUT)
wr_en_y  out  1  y memory write enable
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion

Behaviour:
- One clock, clk; reset is asynchronous and active-low. Reset low forces state IDLE, clears all counters and tag pipe, and drives every output to 0, including in_ready and out_valid.
- Reset mid-job discards the job. Memories are not cleared.
- States: IDLE, LOAD_X, LOAD_A, COMPUTE, OUTPUT.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD_X; load pointer cleared.
  - start is ignored in every other state.
- LOAD_X:
  - in_ready=1; wr_en_x = in_valid; addr_x = load pointer.
  - Pointer advances only on in_valid&in_ready.
  - After word N-1 is written: pointer cleared, -> LOAD_A. Gaps in in_valid stall with no writes.
- LOAD_A:
  - Same rules; addr_a = pointer over 0..M*N-1.
  - After the last word: -> COMPUTE.
- COMPUTE:
  - Issue cycles k=0..M*N-1, with r=k/N, c=k%N: addr_x=c, addr_a=r*N+c.
  - Tag {valid, first=(c==0), last=(c==N-1), row=r} enters the tag pipe.
  - Tag exits after PIPE_LAT cycles: acc_en=valid, acc_first=valid&first.
  - One cycle after a last tag exits: wr_en_y=1, addr_y=row.
  - Back-to-back rows need no bubble; acc_first restarts the sum.
  - Total COMPUTE duration is M*N+PIPE_LAT+1 cycles (19 at defaults). After the final wr_en_y -> OUTPUT, read pointer = 0.
- OUTPUT:
  - addr_y = read pointer; out_valid asserts the cycle after addr_y settles on a new value.
  - Holding addr_y holds data_out stable under out_ready=0.
  - On out_valid&out_ready: pointer++, out_valid=0 for one cycle (one bubble per word).
  - After handshake on word M-1: done=1 for one cycle, -> IDLE.
- wr_en_* never asserted outside its own state.
- acc_en, wr_en_y are 0 outside COMPUTE.
- No arithmetic in this block; counter widths are $clog2 of their range, and addresses are zero-extended to AW.

Decomposition:
- Package mvm_pkg holds:
  - state enum typedef (IDLE..OUTPUT);
  - tag struct typedef {valid, first, last, row};
  - default M, N, AW, PIPE_LAT constants.
- One sub-module, mvm_tag_pipe: a PIPE_LAT-deep tag shift register with async active-low clear.

Test Plan:
- Load x=0,1,2,3 and A=4..19 with continuous in_valid, datapath attached, out_ready=1 -> out words 38, 62, 86, 110 in order; done pulses exactly once, one cycle after the 4th handshake; busy low next cycle.
- Same data with in_valid deasserted every other cycle -> identical y; wr_en_x/wr_en_a asserted exactly 4 and 16 cycles total; no writes on idle cycles.
- COMPUTE timing check -> acc_first high on cycles PIPE_LAT+{0,4,8,12} after COMPUTE entry; wr_en_y with addr_y=0,1,2,3 at entry+{6,10,14,18}; COMPUTE lasts 19 cycles.
- out_ready held low 5 cycles on y[1] -> data_out stays 62 and out_valid stays high throughout; no skip or duplicate of words.
- Assert reset low mid-COMPUTE (cycle 7) -> all outputs 0 immediately (async); state IDLE; a new start then x=1,1,1,1 and A all 2 -> y = 8, 8, 8, 8.
- start pulsed during LOAD_A and OUTPUT -> ignored; exactly one done per job; start in IDLE the cycle after done begins a new job.
